// File: rtl/stack_binop_seq_pkg.sv
// Shared type tags and trap codes for the operand-stack binary-op sequencer.
package stack_binop_seq_pkg;

  localparam int VAL_W  = 64;
  localparam int OP_W   = 8;
  localparam int TYPE_W = 2;
  localparam int TRAP_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    TY_I32 = 2'd0,
    TY_I64 = 2'd1,
    TY_F32 = 2'd2,
    TY_F64 = 2'd3
  } val_type_e;

  typedef enum logic [TRAP_W-1:0] {
    TRAP_NONE          = 3'd0,
    TRAP_UNDERFLOW     = 3'd1,
    TRAP_OVERFLOW      = 3'd2,
    TRAP_TYPE_MISMATCH = 3'd3,
    TRAP_ALU           = 3'd4,
    TRAP_TIMEOUT       = 3'd5
  } trap_e;

endpackage

// File: rtl/stack_binop_seq.sv
// Binary-op sequencer: owns the stack pointer, pushes constants, pops b then a,
// type-checks, runs the ALU handshake and writes the result back; traps are sticky.
module stack_binop_seq
  import stack_binop_seq_pkg::*;
#(
  parameter int STACK_ADDR  = 4,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  input  logic [VAL_W-1:0]        push_data,
  input  logic [TYPE_W-1:0]       push_type,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [OP_W-1:0]         op_code,
  input  logic [TYPE_W-1:0]       op_type,
  output logic [STACK_ADDR-1:0]   stk_addr,
  output logic                    stk_we,
  output logic [VAL_W-1:0]        stk_wdata,
  output logic [TYPE_W-1:0]       stk_wtype,
  input  logic [VAL_W-1:0]        stk_rdata,
  input  logic [TYPE_W-1:0]       stk_rtype,
  output logic                    alu_start,
  output logic [OP_W-1:0]         alu_op,
  output logic [VAL_W-1:0]        alu_a,
  output logic [VAL_W-1:0]        alu_b,
  input  logic                    alu_done,
  input  logic [VAL_W-1:0]        alu_result,
  input  logic                    alu_trap,
  output logic                    done,
  output logic [VAL_W-1:0]        result,
  output logic [TYPE_W-1:0]       result_type,
  output logic                    result_empty,
  output logic [STACK_ADDR:0]     sp,
  output logic [TRAP_W-1:0]       trap
);

  localparam int SP_W  = STACK_ADDR + 1;
  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [SP_W-1:0]  SP_FULL  = {1'b1, {STACK_ADDR{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_B,
    S_RD_A,
    S_CHK,
    S_EXEC,
    S_WAIT,
    S_WB,
    S_TRAP
  } state_e;

  // Control state (reset)
  state_e              state_q, state_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  trap_e               trap_q, trap_d;
  logic [VAL_W-1:0]    result_q, result_d;
  logic [TYPE_W-1:0]   rtype_q, rtype_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Datapath holding registers (no reset)
  logic [OP_W-1:0]     op_q, op_d;
  logic [TYPE_W-1:0]   optype_q, optype_d;
  logic [VAL_W-1:0]    a_q, a_d;
  logic [VAL_W-1:0]    b_q, b_d;
  logic [TYPE_W-1:0]   btype_q, btype_d;
  logic [VAL_W-1:0]    wb_q, wb_d;

  logic [STACK_ADDR-1:0] top_addr;
  assign top_addr = sp_q[STACK_ADDR-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sp_q     <= '0;
      trap_q   <= TRAP_NONE;
      result_q <= '0;
      rtype_q  <= TY_I32;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      trap_q   <= trap_d;
      result_q <= result_d;
      rtype_q  <= rtype_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    optype_q <= optype_d;
    a_q      <= a_d;
    b_q      <= b_d;
    btype_q  <= btype_d;
    wb_q     <= wb_d;
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    trap_d    = trap_q;
    result_d  = result_q;
    rtype_d   = rtype_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    optype_d  = optype_q;
    a_d       = a_q;
    b_d       = b_q;
    btype_d   = btype_q;
    wb_d      = wb_q;
    stk_addr  = top_addr;
    stk_we    = 1'b0;
    stk_wdata = '0;
    stk_wtype = '0;
    alu_start = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (push_valid) begin
          if (sp_q == SP_FULL) begin
            trap_d  = TRAP_OVERFLOW;
            state_d = S_TRAP;
          end else begin
            stk_we    = 1'b1;
            stk_addr  = top_addr;
            stk_wdata = push_data;
            stk_wtype = push_type;
            sp_d      = sp_q + SP_W'(1);
            result_d  = push_data;
            rtype_d   = push_type;
            done      = 1'b1;
          end
        end else if (op_valid) begin
          if (sp_q < SP_W'(2)) begin
            trap_d  = TRAP_UNDERFLOW;
            state_d = S_TRAP;
          end else begin
            op_d     = op_code;
            optype_d = op_type;
            state_d  = S_RD_B;
          end
        end
      end

      S_RD_B: begin
        stk_addr = top_addr - STACK_ADDR'(1);
        state_d  = S_RD_A;
      end

      // Read data for b arrives now; issue the read for a.
      S_RD_A: begin
        b_d      = stk_rdata;
        btype_d  = stk_rtype;
        stk_addr = top_addr - STACK_ADDR'(2);
        state_d  = S_CHK;
      end

      // a is latched even on a mismatch so alu_a/alu_b always reflect the last pop.
      S_CHK: begin
        a_d = stk_rdata;
        if ((stk_rtype != optype_q) || (btype_q != optype_q)) begin
          trap_d  = TRAP_TYPE_MISMATCH;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_start = 1'b1;
        cnt_d     = CNT_W'(1);
        state_d   = S_WAIT;
      end

      // cnt_q counts cycles since alu_start; trap lands ALU_TIMEOUT cycles after it.
      S_WAIT: begin
        if (alu_done) begin
          if (alu_trap) begin
            trap_d  = TRAP_ALU;
            state_d = S_TRAP;
          end else begin
            wb_d    = alu_result;
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          trap_d  = TRAP_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        stk_we    = 1'b1;
        stk_addr  = top_addr - STACK_ADDR'(2);
        stk_wdata = wb_q;
        stk_wtype = optype_q;
        sp_d      = sp_q - SP_W'(1);
        result_d  = wb_q;
        rtype_d   = optype_q;
        done      = 1'b1;
        state_d   = S_IDLE;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase

    // Reset aborts any in-flight write or strobe in the same cycle.
    if (reset) begin
      stk_we    = 1'b0;
      alu_start = 1'b0;
      done      = 1'b0;
    end
  end

  assign op_ready     = (state_q == S_IDLE) && !push_valid && (trap_q == TRAP_NONE);
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign result       = result_q;
  assign result_type  = rtype_q;
  assign result_empty = (sp_q == '0);
  assign sp           = sp_q;
  assign trap         = trap_q;

endmodule
